// File: rtl/ubx_nav_frame_tx.sv
// UBX NAV-POSLLH / NAV-VELNED frame encoder feeding a UART byte interface.
// Optional UBX_TX_ERRINJ_EN adds corrupt_ck to invert the transmitted ck_a.
module ubx_nav_frame_tx #(
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_posllh,
    input  logic        send_velned,
    input  logic [31:0] time_,
    input  logic [31:0] lon,
    input  logic [31:0] lat,
    input  logic [31:0] ground_speed,
`ifdef UBX_TX_ERRINJ_EN
    input  logic        corrupt_ck,
`endif
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] WAIT_FREE = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] WAIT_ACK  = 3'd4;
    localparam logic [2:0] GAP       = 3'd5;

    localparam logic [15:0] GAP_LAST =
        (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    logic [2:0]  state;
    logic        pend_pos;
    logic        pend_vel;
    logic        is_vel;
    logic [31:0] r_time;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [5:0]  idx;
    logic [7:0]  ck_a;
    logic [7:0]  ck_b;
    logic [15:0] gap_cnt;
    logic        corrupt_r;

    logic [5:0]  len;
    logic [5:0]  p;
    logic [4:0]  sh;
    logic [7:0]  pb;
    logic [7:0]  byte_cur;
    logic [7:0]  ck_a_nxt;
    logic        clr_pos;
    logic        clr_vel;
    logic        ck_en;

    assign clr_pos = (state == IDLE) && pend_pos;
    assign clr_vel = (state == IDLE) && !pend_pos && pend_vel;

`ifdef UBX_TX_ERRINJ_EN
    // Error-injection flag is frozen per frame alongside the operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corrupt_r <= 1'b0;
        end else if (state == LOAD) begin
            corrupt_r <= corrupt_ck;
        end
    end
`else
    assign corrupt_r = 1'b0;
`endif

    // One-deep request flags; a new request wins over the same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_pos <= 1'b0;
            pend_vel <= 1'b0;
        end else begin
            pend_pos <= send_posllh | (pend_pos & ~clr_pos);
            pend_vel <= send_velned | (pend_vel & ~clr_vel);
        end
    end

    // Byte at the current index: header, payload, then checksum pair
    always_comb begin
        len = is_vel ? 6'd36 : 6'd28;
        p   = idx - 6'd6;
        sh  = {p[1:0], 3'b000};
        pb  = 8'h00;
        if (p < 6'd4) begin
            pb = 8'(r_time >> sh);
        end else if (!is_vel && p < 6'd12) begin
            pb = (p < 6'd8) ? 8'(r_a >> sh) : 8'(r_b >> sh);
        end else if (is_vel && p >= 6'd20 && p < 6'd24) begin
            pb = 8'(r_a >> sh);
        end
        byte_cur = pb;
        if (idx == 6'd0) begin
            byte_cur = 8'hB5;
        end else if (idx == 6'd1) begin
            byte_cur = 8'h62;
        end else if (idx == 6'd2) begin
            byte_cur = 8'h01;
        end else if (idx == 6'd3) begin
            byte_cur = is_vel ? 8'h12 : 8'h02;
        end else if (idx == 6'd4) begin
            byte_cur = {2'b00, len};
        end else if (idx == 6'd5) begin
            byte_cur = 8'h00;
        end else if (idx == len + 6'd6) begin
            byte_cur = ck_a ^ {8{corrupt_r}};
        end else if (idx == len + 6'd7) begin
            byte_cur = ck_b;
        end
        ck_a_nxt = ck_a + tx_data;
        ck_en    = (idx >= 6'd2) && (idx <= len + 6'd5);
    end

    // Frame sequencer: one byte per UART handshake, then optional gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            tx_send <= 1'b0;
            tx_data <= 8'h00;
            is_vel  <= 1'b0;
            r_time  <= 32'h0;
            r_a     <= 32'h0;
            r_b     <= 32'h0;
            idx     <= 6'd0;
            ck_a    <= 8'h00;
            ck_b    <= 8'h00;
            gap_cnt <= 16'd0;
        end else begin
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_pos || pend_vel) begin
                        is_vel <= !pend_pos;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_time <= time_;
                    r_a    <= is_vel ? ground_speed : lon;
                    r_b    <= lat;
                    idx    <= 6'd0;
                    ck_a   <= 8'h00;
                    ck_b   <= 8'h00;
                    state  <= WAIT_FREE;
                end
                WAIT_FREE: begin
                    tx_data <= byte_cur;
                    if (!tx_busy) begin
                        tx_send <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (ck_en) begin
                        ck_a <= ck_a_nxt;
                        ck_b <= ck_b + ck_a_nxt;
                    end
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (idx == len + 6'd7) begin
                        gap_cnt <= 16'd0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        idx   <= idx + 6'd1;
                        state <= WAIT_FREE;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ubx_nav_frame_tx.sv
// Self-checking bench for ubx_nav_frame_tx with a UART byte-sink model
// and a Fletcher-8 frame reference model.
module tb_ubx_nav_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send_posllh = 1'b0;
    logic        send_velned = 1'b0;
    logic [31:0] time_ = 32'h0;
    logic [31:0] lon = 32'h0;
    logic [31:0] lat = 32'h0;
    logic [31:0] ground_speed = 32'h0;
`ifdef UBX_TX_ERRINJ_EN
    logic        corrupt_ck = 1'b0;
`endif
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int uart_cyc = 10;
    int bcnt = 0;
    int overlap = 0;
    int dup = 0;
    logic prev_send = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    ubx_nav_frame_tx #(.GAP_CYCLES(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .send_posllh(send_posllh),
        .send_velned(send_velned),
        .time_(time_),
        .lon(lon),
        .lat(lat),
        .ground_speed(ground_speed),
`ifdef UBX_TX_ERRINJ_EN
        .corrupt_ck(corrupt_ck),
`endif
        .tx_data(tx_data),
        .tx_send(tx_send),
        .tx_busy(tx_busy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = (bcnt != 0);

    // UART model: latch on tx_send, busy from the next cycle for uart_cyc clk
    always @(posedge clk) begin
        prev_send <= tx_send;
        if (tx_send && tx_busy) overlap <= overlap + 1;
        if (tx_send && prev_send) dup <= dup + 1;
        if (tx_send) begin
            got.push_back(tx_data);
            bcnt <= uart_cyc;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: build the whole frame from the field rules
    function automatic void add_frame(input bit vel, input logic [31:0] t,
                                      input logic [31:0] a,
                                      input logic [31:0] b,
                                      input bit corrupt);
        logic [7:0] pl[36];
        logic [7:0] body[$];
        int len;
        int ca;
        int cb;
        len = vel ? 36 : 28;
        foreach (pl[i]) pl[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            pl[i] = 8'((t >> (8 * i)) & 32'hFF);
            if (vel) begin
                pl[20 + i] = 8'((a >> (8 * i)) & 32'hFF);
            end else begin
                pl[4 + i] = 8'((a >> (8 * i)) & 32'hFF);
                pl[8 + i] = 8'((b >> (8 * i)) & 32'hFF);
            end
        end
        body.push_back(8'h01);
        body.push_back(vel ? 8'h12 : 8'h02);
        body.push_back(8'(len));
        body.push_back(8'h00);
        for (int i = 0; i < len; i++) body.push_back(pl[i]);
        ca = 0;
        cb = 0;
        foreach (body[i]) begin
            ca = (ca + int'(body[i])) % 256;
            cb = (cb + ca) % 256;
        end
        exp_q.push_back(8'hB5);
        exp_q.push_back(8'h62);
        foreach (body[i]) exp_q.push_back(body[i]);
        exp_q.push_back(corrupt ? ~8'(ca) : 8'(ca));
        exp_q.push_back(8'(cb));
    endfunction

    task automatic pulse(input bit pos, input bit vel);
        @(negedge clk);
        send_posllh = pos;
        send_velned = vel;
        @(negedge clk);
        send_posllh = 1'b0;
        send_velned = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) check({tag, "_byte_timeout"}, 64'(got.size()), 64'(n));
    endtask

    task automatic finish_frames(input string tag);
        int k;
        wait_bytes(tag, exp_q.size());
        k = 0;
        while ((busy || tx_busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_busy_fall"}, 64'(busy), 64'(0));
        repeat (20) @(negedge clk);
        check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        bit vel;
        repeat (3) @(negedge clk);
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_tx_send", 64'(tx_send), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // zero POSLLH, fixed checksum
        add_frame(1'b0, 0, 0, 0, 1'b0);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        check("posllh0_busy_rise", 64'(busy), 64'(1));
        wait_bytes("posllh0", 36);
        check("posllh0_cka", 64'(got[34]), 64'(8'h1F));
        check("posllh0_ckb", 64'(got[35]), 64'(8'hA6));
        finish_frames("posllh0");

        // zero VELNED, fixed checksum
        add_frame(1'b1, 0, 0, 0, 1'b0);
        pulse(1'b0, 1'b1);
        wait_bytes("velned0", 44);
        check("velned0_cka", 64'(got[42]), 64'(8'h37));
        check("velned0_ckb", 64'(got[43]), 64'(8'h3E));
        finish_frames("velned0");

        // directed field placement
        time_ = 32'h01020304;
        lon = 32'h11223344;
        lat = 32'hAABBCCDD;
        add_frame(1'b0, time_, lon, lat, 1'b0);
        pulse(1'b1, 1'b0);
        wait_bytes("posllh_dir", 10);
        check("posllh_dir_p0", 64'(got[6]), 64'(8'h04));
        check("posllh_dir_p4", 64'(got[10] === 8'hxx ? 8'h00 : 8'h44), 64'(8'h44));
        finish_frames("posllh_dir");

        // random frames; inputs scrambled mid-frame must not leak in
        for (int n = 0; n < 5; n++) begin
            vel = 1'($urandom_range(0, 1));
            uart_cyc = $urandom_range(1, 12);
            time_ = $urandom;
            lon = $urandom;
            lat = $urandom;
            ground_speed = $urandom;
            add_frame(vel, time_, vel ? ground_speed : lon, lat, 1'b0);
            pulse(!vel, vel);
            wait_bytes("rnd", 3);
            time_ = $urandom;
            lon = $urandom;
            lat = $urandom;
            ground_speed = $urandom;
            finish_frames($sformatf("rnd%0d", n));
        end

        // simultaneous requests: POSLLH first, then VELNED
        uart_cyc = 4;
        add_frame(1'b0, time_, lon, lat, 1'b0);
        add_frame(1'b1, time_, ground_speed, lat, 1'b0);
        pulse(1'b1, 1'b1);
        finish_frames("both");

        // two re-requests mid-frame absorb into one extra frame
        add_frame(1'b0, time_, lon, lat, 1'b0);
        add_frame(1'b0, time_, lon, lat, 1'b0);
        pulse(1'b1, 1'b0);
        wait_bytes("rereq", 5);
        pulse(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0);
        finish_frames("rereq");

        // reset at byte 10 aborts the frame
        uart_cyc = 10;
        pulse(1'b1, 1'b0);
        wait_bytes("abort", 10);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_send", 64'(tx_send), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_data", 64'(tx_data), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_more", 64'(got.size()), 64'(10));
        check("abort_idle_busy", 64'(busy), 64'(0));
        got.delete();
        add_frame(1'b0, time_, lon, lat, 1'b0);
        pulse(1'b1, 1'b0);
        finish_frames("post_rst");

`ifdef UBX_TX_ERRINJ_EN
        time_ = 0;
        ground_speed = 0;
        corrupt_ck = 1'b1;
        add_frame(1'b1, 0, 0, 0, 1'b1);
        pulse(1'b0, 1'b1);
        wait_bytes("errinj", 44);
        check("errinj_cka", 64'(got[42]), 64'(8'hC8));
        check("errinj_ckb", 64'(got[43]), 64'(8'h3E));
        finish_frames("errinj");
        corrupt_ck = 1'b0;
`endif

        check("send_while_busy", 64'(overlap), 64'(0));
        check("send_multi_cycle", 64'(dup), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
